// File: rtl/usb_fifo_pkg.sv
// Shared types and constants for the FX2 slave-FIFO controller.
package usb_fifo_pkg;

  localparam int FD_W = 16;

  localparam logic [1:0] EP2_ADDR = 2'b00;
  localparam logic [1:0] EP6_ADDR = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_SETUP,
    S_RD,
    S_WR_SETUP,
    S_WR,
    S_TURN
  } state_e;

endpackage

// File: rtl/usb_rx_skid.sv
// Two-entry FIFO absorbing EP2 words while the rx consumer stalls.
module usb_rx_skid #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic [1:0]   count_o,
  output logic         full_o,
  output logic         afull_o
);
  logic [W-1:0] mem_q [2];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign full_o  = (cnt_q == 2'd2);
  assign afull_o = (cnt_q == 2'd1);
  assign count_o = cnt_q;
  assign push    = push_i & ~full_o;
  assign pop     = pop_i & (cnt_q != 2'd0);
  assign data_o  = mem_q[rp_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) wp_q <= ~wp_q;
      if (pop)  rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wp_q] <= data_i;
  end

endmodule

// File: rtl/usb_slave_fifo_ctrl.sv
// FX2 synchronous slave-FIFO master: EP2 -> rx stream, tx stream -> EP6,
// bounded bursts with a bus-turnaround cycle between directions.
module usb_slave_fifo_ctrl
  import usb_fifo_pkg::*;
#(
  parameter int         MAX_BURST  = 256,
  parameter logic [1:0] EP_RD_ADDR = EP2_ADDR,
  parameter logic [1:0] EP_WR_ADDR = EP6_ADDR
) (
  input  logic            cyp_clk,
  input  logic            rst,
  output logic [1:0]      usb_fifoaddr,
  output logic            usb_slcs,
  output logic            usb_sloe,
  output logic            usb_slrd,
  output logic            usb_slwr,
  input  logic [FD_W-1:0] usb_fd_i,
  output logic [FD_W-1:0] usb_fd_o,
  output logic            usb_fd_oe,
  input  logic            usb_flaga,
  input  logic            usb_flagc,
  output logic            pa0,
  output logic [FD_W-1:0] rx_data,
  output logic            rx_valid,
  input  logic            rx_ready,
  input  logic [FD_W-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready
);
  localparam int            BW         = $clog2(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          last_wr_q, last_wr_d, cur_wr_q, cur_wr_d;
  logic [1:0]    skid_cnt;
  logic          skid_full, skid_afull, skid_pop;
  logic          rd_req, wr_req, rd_fire, wr_fire;

  assign pa0      = 1'b1;
  assign rx_valid = (skid_cnt != 2'd0);
  assign skid_pop = rx_valid & rx_ready;
  assign rd_req   = usb_flaga & ~skid_full;
  assign wr_req   = usb_flagc & tx_valid;
  assign rd_fire  = (state_q == S_RD) & rd_req;
  assign wr_fire  = (state_q == S_WR) & wr_req;

  usb_rx_skid #(.W(FD_W)) u_skid (
    .clk_i   (cyp_clk),
    .rst_i   (rst),
    .push_i  (rd_fire),
    .data_i  (usb_fd_i),
    .pop_i   (skid_pop),
    .data_o  (rx_data),
    .count_o (skid_cnt),
    .full_o  (skid_full),
    .afull_o (skid_afull)
  );

  always_ff @(posedge cyp_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      burst_q   <= '0;
      last_wr_q <= 1'b1;
      cur_wr_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      burst_q   <= burst_d;
      last_wr_q <= last_wr_d;
      cur_wr_q  <= cur_wr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    last_wr_d    = last_wr_q;
    cur_wr_d     = cur_wr_q;
    usb_slcs     = 1'b1;
    usb_sloe     = 1'b1;
    usb_slrd     = 1'b1;
    usb_slwr     = 1'b1;
    usb_fifoaddr = EP_RD_ADDR;
    usb_fd_oe    = 1'b0;
    usb_fd_o     = '0;
    tx_ready     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rd_req && (!wr_req || last_wr_q)) begin
          state_d  = S_RD_SETUP;
          cur_wr_d = 1'b0;
        end else if (wr_req) begin
          state_d  = S_WR_SETUP;
          cur_wr_d = 1'b1;
        end
      end
      S_RD_SETUP: begin
        usb_slcs = 1'b0;
        usb_sloe = 1'b0;
        state_d  = S_RD;
      end
      S_RD: begin
        usb_slcs = 1'b0;
        usb_sloe = 1'b0;
        usb_slrd = ~rd_fire;
        // Leave as soon as this read will fill the skid, so no read is wasted.
        if (!rd_fire || burst_q == BURST_LAST || (skid_afull && !skid_pop)) begin
          state_d = S_TURN;
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      S_WR_SETUP: begin
        usb_slcs     = 1'b0;
        usb_fifoaddr = EP_WR_ADDR;
        state_d      = S_WR;
      end
      S_WR: begin
        usb_slcs     = 1'b0;
        usb_fifoaddr = EP_WR_ADDR;
        usb_fd_oe    = 1'b1;
        if (wr_fire) begin
          usb_slwr = 1'b0;
          usb_fd_o = tx_data;
          tx_ready = 1'b1;
        end
        if (!wr_fire || burst_q == BURST_LAST) begin
          state_d = S_TURN;
          burst_d = '0;
        end else begin
          burst_d = burst_q + 1'b1;
        end
      end
      S_TURN: begin
        usb_slcs  = 1'b0;
        last_wr_d = cur_wr_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_slave_fifo_ctrl.sv
// Directed bench: FX2 FIFO model on both endpoints plus rx/tx stream agents.
module tb_usb_slave_fifo_ctrl;
  logic        cyp_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  usb_fifoaddr;
  logic        usb_slcs, usb_sloe, usb_slrd, usb_slwr;
  logic [15:0] usb_fd_i, usb_fd_o;
  logic        usb_fd_oe, usb_flaga, usb_flagc, pa0;
  logic [15:0] rx_data, tx_data;
  logic        rx_valid, rx_ready, tx_valid, tx_ready;

  logic [15:0] ep2_mem [64];
  logic [15:0] tx_mem  [64];
  logic [15:0] ep6_got [64];
  logic [15:0] rx_got  [64];
  int          rd_cyc  [64];
  int          pop_cyc [64];
  logic        dir_log [128];
  int ep2_n = 0, ep2_idx = 0, tx_n = 0, tx_idx = 0;
  int ep6_cnt = 0, ep6_lim = 0, rx_cnt = 0, dir_cnt = 0, cyc = 0;
  int bus_err = 0, turn_err = 0, addr_err = 0;
  logic prev_oe = 1'b0, prev_sloe_lo = 1'b0;
  int n_chk = 0, n_err = 0;

  always #5 cyp_clk = ~cyp_clk;

  assign usb_flaga = (ep2_idx < ep2_n);
  assign usb_fd_i  = usb_flaga ? ep2_mem[ep2_idx[5:0]] : 16'h0;
  assign usb_flagc = (ep6_cnt < ep6_lim);
  assign tx_valid  = (tx_idx < tx_n);
  assign tx_data   = tx_mem[tx_idx[5:0]];

  usb_slave_fifo_ctrl #(.MAX_BURST(4), .EP_RD_ADDR(2'b00), .EP_WR_ADDR(2'b10)) dut (
    .cyp_clk(cyp_clk), .rst(rst), .usb_fifoaddr(usb_fifoaddr), .usb_slcs(usb_slcs),
    .usb_sloe(usb_sloe), .usb_slrd(usb_slrd), .usb_slwr(usb_slwr), .usb_fd_i(usb_fd_i),
    .usb_fd_o(usb_fd_o), .usb_fd_oe(usb_fd_oe), .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
    .pa0(pa0), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  // FX2 endpoints and stream agents
  always @(posedge cyp_clk) begin
    cyc <= cyc + 1;
    if (!usb_slrd) begin
      ep2_idx <= ep2_idx + 1;
      rd_cyc[ep2_idx[5:0]] <= cyc;
      dir_log[dir_cnt[6:0]] <= 1'b0;
      dir_cnt <= dir_cnt + 1;
      if (usb_fifoaddr != 2'b00 || usb_slcs) addr_err <= addr_err + 1;
    end
    if (!usb_slwr) begin
      ep6_got[ep6_cnt[5:0]] <= usb_fd_o;
      ep6_cnt <= ep6_cnt + 1;
      dir_log[dir_cnt[6:0]] <= 1'b1;
      dir_cnt <= dir_cnt + 1;
      if (usb_fifoaddr != 2'b10 || usb_slcs || !usb_fd_oe) addr_err <= addr_err + 1;
    end
    if (tx_ready) tx_idx <= tx_idx + 1;
    if (rx_valid && rx_ready) begin
      rx_got[rx_cnt[5:0]]  <= rx_data;
      pop_cyc[rx_cnt[5:0]] <= cyc;
      rx_cnt <= rx_cnt + 1;
    end
  end

  // bus ownership: never both drivers, and an idle cycle between them
  always @(negedge cyp_clk) begin
    if (usb_fd_oe && !usb_sloe) bus_err <= bus_err + 1;
    if ((usb_fd_oe && prev_sloe_lo) || (!usb_sloe && prev_oe)) turn_err <= turn_err + 1;
    prev_oe      <= usb_fd_oe;
    prev_sloe_lo <= !usb_sloe;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    int load_cyc, base, dbase, bad;
    rx_ready = 1'b1;
    repeat (3) @(negedge cyp_clk);
    chk("rst_strobes", {usb_slcs, usb_sloe, usb_slrd, usb_slwr}, 4'hF);
    chk("rst_oe_txr_rxv", {usb_fd_oe, tx_ready, rx_valid}, 3'b000);
    rst = 1'b0;

    // idle with nothing pending
    repeat (5) @(negedge cyp_clk);
    chk("idle_strobes", {usb_slcs, usb_sloe, usb_slrd, usb_slwr}, 4'hF);
    chk("idle_oe", usb_fd_oe, 0);
    chk("idle_pa0", pa0, 1);
    chk("idle_addr_fdo", {usb_fifoaddr, usb_fd_o}, 18'h0);

    // 4-word read burst
    ep2_mem[0] = 16'h1111; ep2_mem[1] = 16'h2222; ep2_mem[2] = 16'h3333; ep2_mem[3] = 16'h4444;
    ep2_n = 4;
    load_cyc = cyc;
    for (int i = 0; i < 100 && rx_cnt < 4; i++) @(negedge cyp_clk);
    chk("rd4_done", rx_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rd4_data%0d", i), rx_got[i], 32'h1111 * (i + 1));
      chk($sformatf("rd4_lat%0d", i), pop_cyc[i] - rd_cyc[i], 1);
    end
    chk("rd4_setup", rd_cyc[0] - load_cyc, 2);
    chk("rd4_contig", rd_cyc[3] - rd_cyc[0], 3);
    repeat (4) @(negedge cyp_clk);
    chk("rd4_back_idle", usb_slcs, 1);

    // consumer stalled: skid fills with exactly 2 words
    rx_ready = 1'b0;
    base = ep2_n;
    for (int i = 0; i < 4; i++) ep2_mem[4 + i] = 16'hB001 + 16'(i);
    ep2_n = 8;
    repeat (15) @(negedge cyp_clk);
    chk("stall_reads", ep2_idx - base, 2);
    chk("stall_head", {rx_valid, rx_data}, {1'b1, 16'hB001});
    chk("stall_idle", {usb_slcs, usb_slrd}, 2'b11);
    rx_ready = 1'b1;
    for (int i = 0; i < 100 && rx_cnt < 8; i++) @(negedge cyp_clk);
    chk("stall_done", rx_cnt, 8);
    for (int i = 0; i < 4; i++) chk($sformatf("stall_data%0d", i), rx_got[4 + i], 32'hB001 + i);

    // writes with EP6 filling after 2 words
    tx_mem[0] = 16'hA5A5; tx_mem[1] = 16'h5A5A; tx_mem[2] = 16'hFFFF;
    ep6_lim = 2;
    tx_n = 3;
    for (int i = 0; i < 100 && ep6_cnt < 2; i++) @(negedge cyp_clk);
    chk("wr_full_cnt", ep6_cnt, 2);
    chk("wr_full_hs", {tx_valid, tx_ready, usb_slwr, usb_fd_oe}, 4'b1011);
    repeat (6) @(negedge cyp_clk);
    chk("wr_full_hold", ep6_cnt, 2);
    chk("wr_data0", ep6_got[0], 16'hA5A5);
    chk("wr_data1", ep6_got[1], 16'h5A5A);
    ep6_lim = 1000;
    for (int i = 0; i < 100 && ep6_cnt < 3; i++) @(negedge cyp_clk);
    chk("wr_resume_cnt", ep6_cnt, 3);
    chk("wr_data2", ep6_got[2], 16'hFFFF);
    repeat (4) @(negedge cyp_clk);

    // both directions continuously pending: 4/4 alternating bursts
    dbase = dir_cnt;
    for (int i = 0; i < 16; i++) begin
      ep2_mem[8 + i] = 16'hC000 + 16'(i);
      tx_mem[3 + i]  = 16'hD000 + 16'(i);
    end
    ep2_n = 24;
    tx_n  = 19;
    for (int i = 0; i < 400 && (rx_cnt < 24 || ep6_cnt < 19); i++) @(negedge cyp_clk);
    chk("alt_done", {rx_cnt[15:0], ep6_cnt[15:0]}, {16'd24, 16'd19});
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (dir_log[7'(dbase + i)] !== 1'((i / 4) & 1)) bad++;
    chk("alt_pattern", bad, 0);
    chk("alt_rx_last", rx_got[23], 16'hC00F);
    chk("alt_tx_last", ep6_got[18], 16'hD00F);
    chk("bus_conflict", bus_err, 0);
    chk("turnaround", turn_err, 0);
    chk("strobe_addr", addr_err, 0);

    // reset mid write burst
    for (int i = 0; i < 8; i++) tx_mem[19 + i] = 16'hE000 + 16'(i);
    base = ep6_cnt;
    tx_n = 27;
    for (int i = 0; i < 100 && ep6_cnt < base + 2; i++) @(negedge cyp_clk);
    chk("mid_wr_active", usb_slwr, 0);
    rst = 1'b1;
    #1;
    chk("async_strobes", {usb_slcs, usb_sloe, usb_slrd, usb_slwr}, 4'hF);
    chk("async_oe_txr", {usb_fd_oe, tx_ready, rx_valid}, 3'b000);
    @(negedge cyp_clk);
    for (int i = 0; i < 4; i++) ep2_mem[24 + i] = 16'hF001 + 16'(i);
    ep2_n = 28;
    repeat (2) @(negedge cyp_clk);
    dbase = dir_cnt;
    rst = 1'b0;
    for (int i = 0; i < 100 && dir_cnt <= dbase; i++) @(negedge cyp_clk);
    chk("post_rst_strobe", dir_cnt > dbase, 1);
    chk("post_rst_rd_first", dir_log[dbase[6:0]], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
